sound_play_ctrl: RTL
====================

Name: sound_play_ctrl

Overview:
Playback sequencer for the audio path. It walks a sample-memory address range at a fixed sample rate and fetches each word through a read-latency handshake. It presents each sample to the PWM stage with a strobe and gates the PWM enable. It supports one-shot and looped clips with start/stop control, and sits between the sample ROM and the PWM modulator.

Parameters:
ADDR_W, 32, sample memory address width
DATA_W, 32, sample word width
DIV_N, 1024, clk cycles per sample period (>=2)
ROM_LAT, 1, memory read latency in clk cycles (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
play  in  1  start request, level, accepted only in IDLE
stop  in  1  abort request, level
loop  in  1  1 = restart at clip_start after clip_end; sampled at each end-of-clip decision
clip_start  in  ADDR_W  first address, latched on play accept
clip_end  in  ADDR_W  last address inclusive, latched on play accept
rom_addr  out  ADDR_W  read address
rom_rd  out  1  read strobe, one cycle per fetch
rom_data  in  DATA_W  read data, valid ROM_LAT cycles after rom_rd
sample  out  DATA_W  current sample to PWM
sample_stb  out  1  one-cycle pulse when sample updates
aud_en  out  1  PWM enable
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on natural end of a one-shot clip

Behaviour:
- Reset (async): state IDLE. All outputs 0. Address, buffer and tick counter cleared.
- Tick counter:
  - Cleared to 0 on play accept.
  - Counts 0..DIV_N-1 while busy; tick = (count == DIV_N-1), then wraps to 0.
  - Frozen at 0 in IDLE.
- States:
  - IDLE:
    - play=1, stop=0 and clip_start<=clip_end: latch the range, addr<=clip_start, go to FETCH.
    - clip_start>clip_end: play ignored, no flag.
  - FETCH: rom_rd=1 and rom_addr=addr for exactly one cycle. Load wait counter with ROM_LAT, go to WAIT.
  - WAIT: decrement the wait counter. At 0, buffer<=rom_data and go to HOLD.
  - HOLD: wait for tick. On the tick edge:
    - sample<=buffer, sample_stb=1, aud_en<=1.
    - addr!=end: addr<=addr+1, go to FETCH.
    - addr==end and loop=1: addr<=start, go to FETCH.
    - addr==end and loop=0: go to DRAIN.
  - DRAIN: hold the last sample. On the next tick: sample<=0, aud_en<=0, done=1 for one cycle, go to IDLE.
- Timing:
  - sample, sample_stb and aud_en are registered; they change the cycle after the tick.
  - First sample_stb comes DIV_N cycles after the play-accept edge.
  - Subsequent strobes are exactly DIV_N cycles apart, looped clips included.
- stop:
  - In any busy state, stop has priority over every other transition.
  - Next cycle: IDLE, aud_en=0, sample=0, rom_rd=0, no done pulse.
  - An in-flight read is discarded.
  - If play and stop are both high in IDLE, the controller stays in IDLE.
- play while busy is ignored. play held high through done restarts the clip on the first IDLE cycle.
- Address arithmetic:
  - ADDR_W modulo.
  - The end compare happens before the increment, so clip_end = all-ones never wraps past the end.
- Late data: a tick arriving in FETCH or WAIT (only when DIV_N < ROM_LAT+3) is lost.
  - No strobe; sample holds its value.
  - The fetched word is emitted on the next tick.
  - The address sequence is unaffected.
- Reset during playback: immediate return to reset values; no done pulse.

Optional Feature:
- Macro SOUND_PLAY_CTRL_UNDERRUN_EN.
- Defined:
  - Adds output underrun_cnt, 8 bits, async reset to 0.
  - Increments on each lost tick (tick while in FETCH or WAIT); saturates at 255.
  - Cleared on play accept.
- Undefined: the port and its logic are absent; lost ticks are silent.

Test Plan:
- One-shot clip. Setup: DIV_N=8, ROM_LAT=1, ROM returns addr+0x100, start=2, end=4, loop=0, pulse play.
  - sample_stb carries 0x102, 0x103, 0x104, 8 cycles apart; first strobe 8 cycles after accept.
  - done pulses 8 cycles after the last strobe; then aud_en=0, sample=0, busy=0.
- Looped clip with stop. loop=1, start=0, end=1:
  - Strobes carry 0x100, 0x101, 0x100, 0x101, ...
  - stop asserted mid-HOLD: next cycle aud_en=0, sample=0, busy=0, no done pulse.
- Invalid range. start=5, end=3, play=1 for 20 cycles: busy stays 0, rom_rd never asserted.
- Async reset. rst asserted mid-WAIT between edges: all outputs 0 immediately, before the next clk edge.
- Held play. start=end=7, loop=0, play held high:
  - Clip repeats, one done per pass.
  - Each new play accept occurs on the first IDLE cycle after done.
- Underrun, macro defined. DIV_N=2, ROM_LAT=3, start=0, end=3:
  - underrun_cnt increments on lost ticks.
  - Strobes still carry 0x100..0x103 in order.

Source files
------------

// File: rtl/sound_play_ctrl.sv
// Sample playback sequencer: walks a ROM address range at one sample per DIV_N clocks.
// Optional macro SOUND_PLAY_CTRL_UNDERRUN_EN adds an 8-bit lost-tick counter output.
module sound_play_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DIV_N   = 1024,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] clip_start,
    input  logic [ADDR_W-1:0] clip_end,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_stb,
    output logic              aud_en,
    output logic              busy,
`ifdef SOUND_PLAY_CTRL_UNDERRUN_EN
    output logic [7:0]        underrun_cnt,
`endif
    output logic              done
);

    localparam int TICK_W = $clog2(DIV_N);
    localparam int WAIT_W = $clog2(ROM_LAT + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV_N - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ROM_LAT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t              state_r, state_nx;
    logic [ADDR_W-1:0]   addr_r, addr_nx;
    logic [ADDR_W-1:0]   start_r, start_nx;
    logic [ADDR_W-1:0]   end_r, end_nx;
    logic [DATA_W-1:0]   buf_r, buf_nx;
    logic [WAIT_W-1:0]   wait_cnt_r, wait_nx;
    logic [TICK_W-1:0]   tick_cnt_r, tick_nx;
    logic [DATA_W-1:0]   sample_r, sample_nx;
    logic                stb_r, stb_nx;
    logic                aud_r, aud_nx;
    logic                done_r, done_nx;
    logic                rom_rd_r;
    logic                busy_r;
    logic                tick_s;
    logic                stop_s;

    assign tick_s = (state_r != S_IDLE) && (tick_cnt_r == TICK_LAST);
    assign stop_s = stop && (state_r != S_IDLE);

    // Next-state and datapath decisions; an abort while busy overrides everything.
    always_comb begin
        state_nx  = state_r;
        addr_nx   = addr_r;
        start_nx  = start_r;
        end_nx    = end_r;
        buf_nx    = buf_r;
        wait_nx   = wait_cnt_r;
        tick_nx   = tick_cnt_r;
        sample_nx = sample_r;
        stb_nx    = 1'b0;
        aud_nx    = aud_r;
        done_nx   = 1'b0;
        if (stop_s) begin
            state_nx  = S_IDLE;
            tick_nx   = '0;
            sample_nx = '0;
            aud_nx    = 1'b0;
        end else begin
            if ((state_r == S_IDLE) || tick_s) begin
                tick_nx = '0;
            end else begin
                tick_nx = tick_cnt_r + TICK_ONE;
            end
            case (state_r)
                S_IDLE: begin
                    if (play && !stop && (clip_start <= clip_end)) begin
                        start_nx = clip_start;
                        end_nx   = clip_end;
                        addr_nx  = clip_start;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
                S_FETCH: begin
                    wait_nx  = WAIT_LOAD;
                    state_nx = S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_r == '0) begin
                        buf_nx   = rom_data;
                        state_nx = S_HOLD;
                    end else begin
                        wait_nx  = wait_cnt_r - WAIT_ONE;
                        state_nx = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (tick_s) begin
                        sample_nx = buf_r;
                        stb_nx    = 1'b1;
                        aud_nx    = 1'b1;
                        // End test precedes the increment so an all-ones end never wraps.
                        if (addr_r != end_r) begin
                            addr_nx  = addr_r + ADDR_ONE;
                            state_nx = S_FETCH;
                        end else if (loop) begin
                            addr_nx  = start_r;
                            state_nx = S_FETCH;
                        end else begin
                            state_nx = S_DRAIN;
                        end
                    end else begin
                        state_nx = S_HOLD;
                    end
                end
                S_DRAIN: begin
                    if (tick_s) begin
                        sample_nx = '0;
                        aud_nx    = 1'b0;
                        done_nx   = 1'b1;
                        state_nx  = S_IDLE;
                    end else begin
                        state_nx = S_DRAIN;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            addr_r     <= '0;
            start_r    <= '0;
            end_r      <= '0;
            buf_r      <= '0;
            wait_cnt_r <= '0;
            tick_cnt_r <= '0;
            sample_r   <= '0;
            stb_r      <= 1'b0;
            aud_r      <= 1'b0;
            done_r     <= 1'b0;
            rom_rd_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx;
            addr_r     <= addr_nx;
            start_r    <= start_nx;
            end_r      <= end_nx;
            buf_r      <= buf_nx;
            wait_cnt_r <= wait_nx;
            tick_cnt_r <= tick_nx;
            sample_r   <= sample_nx;
            stb_r      <= stb_nx;
            aud_r      <= aud_nx;
            done_r     <= done_nx;
            rom_rd_r   <= (state_nx == S_FETCH);
            busy_r     <= (state_nx != S_IDLE);
        end
    end

`ifdef SOUND_PLAY_CTRL_UNDERRUN_EN
    logic       underrun_r;
    logic [7:0] underrun_cnt_r;
    logic       accept_s;
    logic       lost_tick_s;

    assign accept_s    = (state_r == S_IDLE) && (state_nx == S_FETCH);
    assign lost_tick_s = tick_s && !stop && ((state_r == S_FETCH) || (state_r == S_WAIT));
    assign underrun_r  = (underrun_cnt_r != 8'hFF);

    // Lost-tick counter: cleared on each accepted play, saturating at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt_r <= 8'h00;
        end else if (accept_s) begin
            underrun_cnt_r <= 8'h00;
        end else if (lost_tick_s && underrun_r) begin
            underrun_cnt_r <= underrun_cnt_r + 8'h01;
        end else begin
            underrun_cnt_r <= underrun_cnt_r;
        end
    end

    assign underrun_cnt = underrun_cnt_r;
`endif

    assign rom_addr   = addr_r;
    assign rom_rd     = rom_rd_r;
    assign sample     = sample_r;
    assign sample_stb = stb_r;
    assign aud_en     = aud_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
